// File: rtl/red_pitaya_dac_slew_pkg.sv
// Shared types and helpers for the DAC slew-rate limiter.
// Holds the FSM state encoding, the default sample width and the
// offset-binary conversion used to drive the DAC IC.
package red_pitaya_dac_pkg;

    localparam int DAC_DW = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dac_state_t;

    // Two's complement to offset binary: keep the sign bit, invert the rest.
    function automatic logic [DAC_DW-1:0] offset_bin(input logic [DAC_DW-1:0] v);
        return {v[DAC_DW-1], ~v[DAC_DW-2:0]};
    endfunction

endpackage

// File: rtl/red_pitaya_dac_slew_if.sv
// Channel-side bus of the DAC slew stage: sample stream and controls in,
// limited sample, offset-binary copy and status out.
// master = channel generator / control side, slave = slew stage.
interface red_pitaya_dac_slew_if #(
    parameter int DW = 14,
    parameter int CW = 32
);
    logic signed [DW-1:0] dat_i;
    logic                 en_i;
    logic        [DW-1:0] set_slew_i;
    logic signed [DW-1:0] dac_o;
    logic        [DW-1:0] dac_ob_o;
    logic                 busy_o;
    logic                 limit_o;
    logic        [CW-1:0] limit_cnt_o;

    modport master (
        output dat_i,
        output en_i,
        output set_slew_i,
        input  dac_o,
        input  dac_ob_o,
        input  busy_o,
        input  limit_o,
        input  limit_cnt_o
    );

    modport slave (
        input  dat_i,
        input  en_i,
        input  set_slew_i,
        output dac_o,
        output dac_ob_o,
        output busy_o,
        output limit_o,
        output limit_cnt_o
    );
endinterface

// File: rtl/red_pitaya_dac_slew_step.sv
// Combinational single-step slew limiter.
// Moves y toward target t by at most s per call; s == 0 jumps straight to t.
// The result always lies between y and t, so the narrow add/subtract
// below never wraps even though it is done in DW bits.
module red_pitaya_slew_step #(
    parameter int DW = 14
) (
    input  logic signed [DW-1:0] y,
    input  logic signed [DW-1:0] t,
    input  logic        [DW-1:0] s,
    output logic signed [DW-1:0] y_next,
    output logic                 clipped
);
    logic signed [DW:0] diff;
    logic signed [DW:0] s_pos;
    logic signed [DW:0] s_neg;

    // Compare the signed distance to the step bound and clip if it exceeds it.
    always_comb begin
        diff    = {t[DW-1], t} - {y[DW-1], y};
        s_pos   = {1'b0, s};
        s_neg   = -s_pos;
        y_next  = t;
        clipped = 1'b0;
        if (s != '0) begin
            if (diff > s_pos) begin
                y_next  = y + s;
                clipped = 1'b1;
            end else if (diff < s_neg) begin
                y_next  = y - s;
                clipped = 1'b1;
            end
        end
    end
endmodule

// File: rtl/red_pitaya_dac_slew.sv
// DAC output conditioning for one generator channel: slew-rate limiting,
// ramp-up from zero on enable, ramp-down to zero on disable, and
// offset-binary presentation for the DAC IC.
// Optional: define DAC_SLEW_CNT_EN to build the saturating clipped-cycle
// counter; without it limit_cnt_o is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | output parked at 0, waiting for enable
// ST_RUN   | tracking the input sample through the limiter
// ST_DRAIN | enable dropped, ramping output back down to 0
module red_pitaya_dac_slew
    import red_pitaya_dac_pkg::*;
#(
    parameter int DW = DAC_DW,
    parameter int CW = 32
) (
    input  logic                 dac_clk_i,
    input  logic                 dac_rst_i,
    red_pitaya_dac_slew_if.slave bus
);
    dac_state_t state;
    dac_state_t state_nxt;

    logic signed [DW-1:0] dat_r;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] y_d;
    logic signed [DW-1:0] target;
    logic signed [DW-1:0] step_y;
    logic                 step_clip;
    logic                 limit_r;
    logic                 limit_d;
    logic                 busy;

    red_pitaya_slew_step #(.DW(DW)) u_step (
        .y       (y),
        .t       (target),
        .s       (bus.set_slew_i),
        .y_next  (step_y),
        .clipped (step_clip)
    );

    // State register.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; re-enable during drain wins over reaching zero.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.en_i) state_nxt = ST_RUN;
            ST_RUN:   if (!bus.en_i) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.en_i) begin
                    state_nxt = ST_RUN;
                end else if (y == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: pick the limiter target and the next output values.
    always_comb begin
        target  = '0;
        y_d     = step_y;
        limit_d = step_clip;
        busy    = 1'b1;
        case (state)
            ST_RUN:   target = dat_r;
            ST_DRAIN: target = '0;
            default: begin
                y_d     = '0;
                limit_d = 1'b0;
                busy    = 1'b0;
            end
        endcase
    end

    // Input sample register and limited output register.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            dat_r   <= '0;
            y       <= '0;
            limit_r <= 1'b0;
        end else begin
            dat_r   <= bus.dat_i;
            y       <= y_d;
            limit_r <= limit_d;
        end
    end

`ifdef DAC_SLEW_CNT_EN
    logic [CW-1:0] limit_cnt;

    // Count clipped steps since the last start; hold at all-ones.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            limit_cnt <= '0;
        end else if (state == ST_IDLE && state_nxt == ST_RUN) begin
            limit_cnt <= '0;
        end else if (limit_d && (limit_cnt != '1)) begin
            limit_cnt <= limit_cnt + CW'(1);
        end
    end

    assign bus.limit_cnt_o = limit_cnt;
`else
    assign bus.limit_cnt_o = {CW{1'b0}};
`endif

    generate
        if (DW == DAC_DW) begin : g_ob_pkg
            assign bus.dac_ob_o = offset_bin(y);
        end else begin : g_ob_generic
            assign bus.dac_ob_o = {y[DW-1], ~y[DW-2:0]};
        end
    endgenerate

    assign bus.dac_o   = y;
    assign bus.limit_o = limit_r;
    assign bus.busy_o  = busy;
endmodule

// File: tb/tb_red_pitaya_dac_slew.sv
// Directed testbench for red_pitaya_dac_slew: reset, bypass, ramp up,
// drain, re-enable during drain, mid-ramp reset, full-scale steps and
// (with DAC_SLEW_CNT_EN) counter saturation.
module tb_red_pitaya_dac_slew;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    red_pitaya_dac_slew_if #(.DW(14), .CW(32)) bus ();

    red_pitaya_dac_slew #(.DW(14), .CW(32)) dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

`ifdef DAC_SLEW_CNT_EN
    localparam logic [31:0] CNT_RAMP = 32'd9;
`else
    localparam logic [31:0] CNT_RAMP = 32'd0;
`endif

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en_i = 1'b0; bus.dat_i = 14'sd5000; bus.set_slew_i = 14'd0;
        tick(); tick();
        total++;
        if (bus.dac_o !== 14'sd0 || bus.dac_ob_o !== 14'h1FFF || bus.busy_o !== 1'b0 ||
            bus.limit_o !== 1'b0 || bus.limit_cnt_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_state dac=%0d ob=%h busy=%b lim=%b cnt=%0d want 0/1fff/0/0/0",
                     bus.dac_o, bus.dac_ob_o, bus.busy_o, bus.limit_o, bus.limit_cnt_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.dac_o !== 14'sd0 || bus.dac_ob_o !== 14'h1FFF || bus.busy_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold[%0d] dac=%0d ob=%h busy=%b want 0/1fff/0",
                         i, bus.dac_o, bus.dac_ob_o, bus.busy_o);
            end
        end
    endtask

    task automatic test_bypass();
        bus.set_slew_i = 14'd0; bus.en_i = 1'b1; bus.dat_i = 14'sd0;
        tick();
        total++;
        if (bus.dac_o !== 14'sd0 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL bypass_start dac=%0d busy=%b want 0/1", bus.dac_o, bus.busy_o);
        end
        bus.dat_i = 14'sd1;
        for (int k = 2; k <= 12; k++) begin
            tick();
            total++;
            if (bus.dac_o !== 14'(k - 2) || bus.limit_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                bad++;
                $display("FAIL bypass[%0d] dac=%0d lim=%b busy=%b want %0d/0/1",
                         k, bus.dac_o, bus.limit_o, bus.busy_o, k - 2);
            end
            bus.dat_i = 14'(k);
        end
        bus.en_i = 1'b0;
        tick();
        total++;
        if (bus.dac_o !== 14'sd11 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL bypass_fall dac=%0d busy=%b want 11/1", bus.dac_o, bus.busy_o);
        end
        tick();
        total++;
        if (bus.dac_o !== 14'sd0 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL bypass_drain dac=%0d busy=%b want 0/1", bus.dac_o, bus.busy_o);
        end
        tick();
        total++;
        if (bus.dac_o !== 14'sd0 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL bypass_idle dac=%0d busy=%b want 0/0", bus.dac_o, bus.busy_o);
        end
    endtask

    task automatic test_ramp();
        bus.set_slew_i = 14'd100; bus.dat_i = 14'sd1000; bus.en_i = 1'b1;
        tick();
        total++;
        if (bus.dac_o !== 14'sd0 || bus.limit_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL ramp_start dac=%0d lim=%b busy=%b want 0/0/1",
                     bus.dac_o, bus.limit_o, bus.busy_o);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            total++;
            if (bus.dac_o !== 14'(100 * i) || bus.limit_o !== 1'b1) begin
                bad++;
                $display("FAIL ramp[%0d] dac=%0d lim=%b want %0d/1", i, bus.dac_o, bus.limit_o, 100 * i);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus.dac_o !== 14'sd1000 || bus.limit_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                bad++;
                $display("FAIL ramp_hold[%0d] dac=%0d lim=%b busy=%b want 1000/0/1",
                         i, bus.dac_o, bus.limit_o, bus.busy_o);
            end
        end
        total++;
        if (bus.limit_cnt_o !== CNT_RAMP) begin
            bad++;
            $display("FAIL ramp_cnt cnt=%0d want %0d", bus.limit_cnt_o, CNT_RAMP);
        end
    endtask

    task automatic test_drain();
        logic signed [13:0] exp_y [4] = '{14'sd700, 14'sd400, 14'sd100, 14'sd0};
        logic               exp_l [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.set_slew_i = 14'd300; bus.en_i = 1'b0;
        tick();
        total++;
        if (bus.dac_o !== 14'sd1000 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL drain_entry dac=%0d busy=%b want 1000/1", bus.dac_o, bus.busy_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.dac_o !== exp_y[i] || bus.limit_o !== exp_l[i] || bus.busy_o !== 1'b1) begin
                bad++;
                $display("FAIL drain[%0d] dac=%0d lim=%b busy=%b want %0d/%b/1",
                         i, bus.dac_o, bus.limit_o, bus.busy_o, exp_y[i], exp_l[i]);
            end
        end
        tick();
        total++;
        if (bus.dac_o !== 14'sd0 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL drain_idle dac=%0d busy=%b want 0/0", bus.dac_o, bus.busy_o);
        end
    endtask

    task automatic test_reenter();
        logic signed [13:0] exp_y [5] = '{14'sd100, -14'sd200, -14'sd500, -14'sd800, -14'sd1000};
        logic               exp_l [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.set_slew_i = 14'd1000; bus.dat_i = 14'sd1000; bus.en_i = 1'b1;
        tick(); tick();
        total++;
        if (bus.dac_o !== 14'sd1000 || bus.limit_o !== 1'b0) begin
            bad++;
            $display("FAIL reenter_setup dac=%0d lim=%b want 1000/0", bus.dac_o, bus.limit_o);
        end
        bus.en_i = 1'b0; bus.set_slew_i = 14'd300;
        tick(); tick(); tick();
        total++;
        if (bus.dac_o !== 14'sd400 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL reenter_at400 dac=%0d busy=%b want 400/1", bus.dac_o, bus.busy_o);
        end
        bus.en_i = 1'b1; bus.dat_i = -14'sd1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus.dac_o !== exp_y[i] || bus.limit_o !== exp_l[i] || bus.busy_o !== 1'b1) begin
                bad++;
                $display("FAIL reenter[%0d] dac=%0d lim=%b busy=%b want %0d/%b/1",
                         i, bus.dac_o, bus.limit_o, bus.busy_o, exp_y[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.set_slew_i = 14'd0; bus.dat_i = 14'sd2000;
        tick(); tick();
        total++;
        if (bus.dac_o !== 14'sd2000) begin
            bad++;
            $display("FAIL rstmid_setup dac=%0d want 2000", bus.dac_o);
        end
        bus.set_slew_i = 14'd50; bus.dat_i = 14'sd3000;
        tick(); tick();
        total++;
        if (bus.dac_o !== 14'sd2050 || bus.limit_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ramp dac=%0d lim=%b busy=%b want 2050/1/1",
                     bus.dac_o, bus.limit_o, bus.busy_o);
        end
        rst = 1'b1; bus.en_i = 1'b0;
        tick();
        total++;
        if (bus.dac_o !== 14'sd0 || bus.dac_ob_o !== 14'h1FFF || bus.busy_o !== 1'b0 ||
            bus.limit_o !== 1'b0 || bus.limit_cnt_o !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_cut dac=%0d ob=%h busy=%b lim=%b cnt=%0d want 0/1fff/0/0/0",
                     bus.dac_o, bus.dac_ob_o, bus.busy_o, bus.limit_o, bus.limit_cnt_o);
        end
        rst = 1'b0;
        tick();
        total++;
        if (bus.dac_o !== 14'sd0 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_after dac=%0d busy=%b want 0/0", bus.dac_o, bus.busy_o);
        end
    endtask

    task automatic test_fullscale();
        bus.set_slew_i = 14'd16383; bus.dat_i = 14'h2000; bus.en_i = 1'b1;
        tick(); tick();
        total++;
        if (bus.dac_o !== 14'h2000 || bus.dac_ob_o !== 14'h3FFF || bus.limit_o !== 1'b0) begin
            bad++;
            $display("FAIL fs_min dac=%0d ob=%h lim=%b want -8192/3fff/0",
                     bus.dac_o, bus.dac_ob_o, bus.limit_o);
        end
        bus.dat_i = 14'h1FFF;
        tick(); tick();
        total++;
        if (bus.dac_o !== 14'h1FFF || bus.dac_ob_o !== 14'h0000 || bus.limit_o !== 1'b0) begin
            bad++;
            $display("FAIL fs_jump dac=%0d ob=%h lim=%b want 8191/0000/0",
                     bus.dac_o, bus.dac_ob_o, bus.limit_o);
        end
        bus.set_slew_i = 14'd16382; bus.dat_i = 14'h2000;
        tick(); tick();
        total++;
        if (bus.dac_o !== 14'h2001 || bus.dac_ob_o !== 14'h3FFE || bus.limit_o !== 1'b1) begin
            bad++;
            $display("FAIL fs_clip dac=%0d ob=%h lim=%b want -8191/3ffe/1",
                     bus.dac_o, bus.dac_ob_o, bus.limit_o);
        end
        tick();
        total++;
        if (bus.dac_o !== 14'h2000 || bus.limit_o !== 1'b0) begin
            bad++;
            $display("FAIL fs_settle dac=%0d lim=%b want -8192/0", bus.dac_o, bus.limit_o);
        end
        bus.set_slew_i = 14'd0; bus.en_i = 1'b0;
        tick(); tick(); tick();
        total++;
        if (bus.dac_o !== 14'sd0 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL fs_idle dac=%0d busy=%b want 0/0", bus.dac_o, bus.busy_o);
        end
    endtask

`ifdef DAC_SLEW_CNT_EN
    task automatic test_cnt_sat();
        bus.set_slew_i = 14'd1; bus.dat_i = 14'sd1000; bus.en_i = 1'b1;
        tick(); tick(); tick();
        force dut.limit_cnt = '1;
        tick();
        release dut.limit_cnt;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus.limit_cnt_o !== 32'hFFFF_FFFF || bus.limit_o !== 1'b1) begin
                bad++;
                $display("FAIL cnt_sat[%0d] cnt=%h lim=%b want ffffffff/1",
                         i, bus.limit_cnt_o, bus.limit_o);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_ramp();
        test_drain();
        test_reenter();
        test_reset_mid();
        test_fullscale();
`ifdef DAC_SLEW_CNT_EN
        test_cnt_sat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
